amt_recovery_seq: RTL



---
 rtl/amt_recovery_seq_pkg.sv | 41 ++++
 rtl/amt_recovery_lane_gen.sv | 22 ++
 rtl/amt_recovery_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/amt_recovery_seq_pkg.sv
// Shared definitions for the AMT -> RMT recovery sequencer.
// Width constants follow the global SIZE_RMT / SIZE_RMT_LOG / SIZE_PHYSICAL_LOG
// defines, with defaults supplied here when the build does not set them.
// Optional perf counters in the top are enabled by AMT_RECOVERY_PERF_EN.

`ifndef SIZE_RMT
`define SIZE_RMT 34
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 6
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

package amt_recovery_seq_pkg;

  localparam int SIZE_RMT          = `SIZE_RMT;
  localparam int SIZE_RMT_LOG      = `SIZE_RMT_LOG;
  localparam int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG;
  localparam int LANES             = 4;

  // Base counter carries one extra bit so base+LANES never wraps.
  localparam int BASE_W = SIZE_RMT_LOG + 1;
  localparam int PKT_W  = SIZE_RMT_LOG + SIZE_PHYSICAL_LOG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // RMT write packet layout: logical index in the upper bits, tag below.
  function automatic logic [PKT_W-1:0] pack_packet(
    input logic [SIZE_RMT_LOG-1:0]      idx,
    input logic [SIZE_PHYSICAL_LOG-1:0] tag
  );
    return {idx, tag};
  endfunction

endpackage

// File: rtl/amt_recovery_lane_gen.sv
// Per-lane AMT index and valid mask for one walk group starting at base_i.
// Purely combinational; lanes past the last logical register drive index 0.

module amt_recovery_lane_gen
  import amt_recovery_seq_pkg::*;
(
  input  logic [BASE_W-1:0]             base_i,
  output logic [LANES*SIZE_RMT_LOG-1:0] idx_o,
  output logic [LANES-1:0]              valid_o
);

  localparam logic [BASE_W-1:0] SIZE_RMT_B = BASE_W'(SIZE_RMT);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BASE_W-1:0] sum;
    assign sum         = base_i + BASE_W'(gi);
    assign valid_o[gi] = (sum < SIZE_RMT_B);
    assign idx_o[gi*SIZE_RMT_LOG +: SIZE_RMT_LOG] =
      valid_o[gi] ? sum[SIZE_RMT_LOG-1:0] : '0;
  end

endmodule

// File: rtl/amt_recovery_seq.sv
// AMT -> RMT recovery sequencer. On a recovery request it walks all AMT
// entries LANES at a time, registers the returned mappings into RMT write
// packets and holds commit stalled until the final group has been written.
// Optional perf counters: define AMT_RECOVERY_PERF_EN; otherwise the perf
// ports are tied to zero.

module amt_recovery_seq
  import amt_recovery_seq_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       recoverReq_i,
  input  logic [LANES-1:0]                           commitValid_i,
  output logic [LANES*SIZE_RMT_LOG-1:0]              amtRdIdx_o,
  input  logic [LANES*SIZE_PHYSICAL_LOG-1:0]         amtRdData_i,
  output logic [LANES-1:0]                           rmtWe_o,
  output logic [LANES*PKT_W-1:0]                     rmtPacket_o,
  output logic                                       commitStall_o,
  output logic                                       flRestore_o,
  output logic                                       recoverDone_o,
  output logic                                       protocolErr_o,
  output logic [31:0]                                perfRecovCnt_o,
  output logic [31:0]                                perfStallCnt_o
);

  localparam logic [BASE_W-1:0] SIZE_RMT_B = BASE_W'(SIZE_RMT);
  localparam logic [BASE_W-1:0] LANES_B    = BASE_W'(LANES);

  state_e                   state_q, state_d;
  logic [BASE_W-1:0]        base_q, base_d;
  logic [LANES-1:0]         rmt_we_q, rmt_we_d;
  logic [LANES*PKT_W-1:0]   rmt_packet_q, rmt_packet_d;
  logic                     fl_restore_q, fl_restore_d;
  logic                     recover_done_q, recover_done_d;
  logic                     protocol_err_q, protocol_err_d;

  logic [LANES*SIZE_RMT_LOG-1:0] lane_idx;
  logic [LANES-1:0]              lane_valid;
  logic [LANES*PKT_W-1:0]        walk_packet;
  logic [BASE_W-1:0]             base_next;
  logic                          commit_stall;

  amt_recovery_lane_gen u_lane_gen (
    .base_i  (base_q),
    .idx_o   (lane_idx),
    .valid_o (lane_valid)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
    assign walk_packet[gi*PKT_W +: PKT_W] =
      pack_packet(lane_idx[gi*SIZE_RMT_LOG +: SIZE_RMT_LOG],
                  amtRdData_i[gi*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG]);
  end

  assign commit_stall = (state_q == WALK) || (state_q == FLUSH);
  assign base_next    = base_q + LANES_B;

  // The AMT is only addressed during the walk; elsewhere the read ports idle at 0.
  assign amtRdIdx_o    = (state_q == WALK) ? lane_idx : '0;
  assign commitStall_o = commit_stall;
  assign rmtWe_o       = rmt_we_q;
  assign rmtPacket_o   = rmt_packet_q;
  assign flRestore_o   = fl_restore_q;
  assign recoverDone_o = recover_done_q;
  assign protocolErr_o = protocol_err_q;

  // Next-state logic for the walk FSM and its registered outputs.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    rmt_we_d       = '0;
    rmt_packet_d   = rmt_packet_q;
    fl_restore_d   = 1'b0;
    recover_done_d = 1'b0;
    protocol_err_d = protocol_err_q | (commit_stall & (|commitValid_i));
    case (state_q)
      IDLE: begin
        if (recoverReq_i) begin
          state_d      = WALK;
          base_d       = '0;
          fl_restore_d = 1'b1;
        end
      end
      WALK: begin
        rmt_we_d     = lane_valid;
        rmt_packet_d = walk_packet;
        base_d       = base_next;
        // The group just read is the last one: its writes land during FLUSH.
        if (base_next >= SIZE_RMT_B) begin
          state_d        = FLUSH;
          recover_done_d = 1'b1;
        end
      end
      FLUSH: begin
        // Requests seen here are not latched; a still-high request restarts from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset (aborts any walk in flight).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      rmt_we_q       <= '0;
      rmt_packet_q   <= '0;
      fl_restore_q   <= 1'b0;
      recover_done_q <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      rmt_we_q       <= rmt_we_d;
      rmt_packet_q   <= rmt_packet_d;
      fl_restore_q   <= fl_restore_d;
      recover_done_q <= recover_done_d;
      protocol_err_q <= protocol_err_d;
    end
  end

`ifdef AMT_RECOVERY_PERF_EN
  logic [31:0] perf_recov_q, perf_recov_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count recovery starts and stalled cycles; both wrap at 2^32.
  always_comb begin
    perf_recov_d = perf_recov_q + (((state_q == IDLE) && recoverReq_i) ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q + (commit_stall ? 32'd1 : 32'd0);
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_recov_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_recov_q <= perf_recov_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perfRecovCnt_o = perf_recov_q;
  assign perfStallCnt_o = perf_stall_q;
`else
  assign perfRecovCnt_o = '0;
  assign perfStallCnt_o = '0;
`endif

endmodule
